// File: rtl/mux_share_arbiter.sv
`default_nettype none
// ============================================================================
// mux_share_arbiter
// Round-robin sharing of one 2:1 datapath mux between two valid/ready
// requesters, feeding a single-entry registered output stage.
// Revision: 1.0
// ============================================================================
module mux_share_arbiter #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_ready,
    output logic             select,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_src,
    input  logic             out_ready,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b
);

    localparam logic [0:0] S_EMPTY = 1'b0;
    localparam logic [0:0] S_FULL  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             src_q, src_d;
    logic             last_grant_q, last_grant_d;
    logic             sel_q, sel_d;
    logic [CNT_W-1:0] cnt_a_q, cnt_a_d;
    logic [CNT_W-1:0] cnt_b_q, cnt_b_d;

    logic             w_can_accept;
    logic             w_gnt_vld;
    logic             w_gnt_b;
    logic             w_accept;
    logic [WIDTH-1:0] w_mux;

    // Under contention the winner is whichever side did not win last time.
    assign w_gnt_vld    = a_valid | b_valid;
    assign w_gnt_b      = b_valid & (~a_valid | ~last_grant_q);
    assign w_can_accept = (state_q == S_EMPTY) | out_ready;

    assign a_ready  = rst_n & w_can_accept & a_valid & ~w_gnt_b;
    assign b_ready  = rst_n & w_can_accept & w_gnt_b;
    assign select   = rst_n & (w_gnt_vld ? w_gnt_b : sel_q);
    assign w_accept = (a_valid & a_ready) | (b_valid & b_ready);
    assign w_mux    = select ? b_data : a_data;

    always_comb begin
        state_d      = state_q;
        data_d       = data_q;
        src_d        = src_q;
        last_grant_d = last_grant_q;
        sel_d        = w_gnt_vld ? w_gnt_b : sel_q;
        cnt_a_d      = cnt_a_q;
        cnt_b_d      = cnt_b_q;
        if (w_accept) begin
            state_d      = S_FULL;
            data_d       = w_mux;
            src_d        = w_gnt_b;
            last_grant_d = w_gnt_b;
            if (w_gnt_b) begin
                cnt_b_d = cnt_b_q + CNT_W'(1);
            end else begin
                cnt_a_d = cnt_a_q + CNT_W'(1);
            end
        end else if ((state_q == S_FULL) && out_ready) begin
            // Drained with nothing to replace it; data is left stale.
            state_d = S_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_EMPTY;
            data_q       <= '0;
            src_q        <= 1'b0;
            last_grant_q <= 1'b1;
            sel_q        <= 1'b0;
            cnt_a_q      <= '0;
            cnt_b_q      <= '0;
        end else begin
            state_q      <= state_d;
            data_q       <= data_d;
            src_q        <= src_d;
            last_grant_q <= last_grant_d;
            sel_q        <= sel_d;
            cnt_a_q      <= cnt_a_d;
            cnt_b_q      <= cnt_b_d;
        end
    end

    assign out_valid = (state_q == S_FULL);
    assign out_data  = data_q;
    assign out_src   = src_q;
    assign cnt_a     = cnt_a_q;
    assign cnt_b     = cnt_b_q;

endmodule
`default_nettype wire

// File: tb/tb_mux_share_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mux_share_arbiter
// Directed vector table plus hand sequences for reset and counter wrap.
// Revision: 1.0
// ============================================================================
module tb_mux_share_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        a_valid = 1'b0, b_valid = 1'b0, out_ready = 1'b0;
    logic [63:0] a_data = '0, b_data = '0;
    logic        a_ready, b_ready, select, out_valid, out_src;
    logic [63:0] out_data;
    logic [15:0] cnt_a, cnt_b;
    logic        a_ready4, b_ready4, select4, out_valid4, out_src4;
    logic [63:0] out_data4;
    logic [3:0]  cnt_a4, cnt_b4;

    int pass_cnt = 0;
    int total    = 0;

    always #5 clk = ~clk;

    mux_share_arbiter #(.WIDTH(64), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
        .select(select), .out_valid(out_valid), .out_data(out_data),
        .out_src(out_src), .out_ready(out_ready),
        .cnt_a(cnt_a), .cnt_b(cnt_b)
    );

    mux_share_arbiter #(.WIDTH(64), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready4),
        .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready4),
        .select(select4), .out_valid(out_valid4), .out_data(out_data4),
        .out_src(out_src4), .out_ready(out_ready),
        .cnt_a(cnt_a4), .cnt_b(cnt_b4)
    );

    typedef struct {
        logic        av, bv, ordy;
        logic [63:0] ad, bd;
        logic        ear, ebr, esel;
        logic        eov;
        logic [63:0] eod;
        logic        esrc;
        logic [15:0] eca, ecb;
    } vec_t;

    vec_t tv [18];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic vec_t mk(input logic av, input logic bv, input logic ordy,
                                input logic [63:0] ad, input logic [63:0] bd,
                                input logic ear, input logic ebr, input logic esel,
                                input logic eov, input logic [63:0] eod, input logic esrc,
                                input logic [15:0] eca, input logic [15:0] ecb);
        vec_t v;
        v.av = av; v.bv = bv; v.ordy = ordy; v.ad = ad; v.bd = bd;
        v.ear = ear; v.ebr = ebr; v.esel = esel;
        v.eov = eov; v.eod = eod; v.esrc = esrc; v.eca = eca; v.ecb = ecb;
        return v;
    endfunction

    initial begin
        //            av bv or  ad  bd  ar br sel  ov od src ca cb
        tv[0]  = mk(1, 0, 1, 15, 12, 1, 0, 0,  1, 15, 0, 1, 0); // single A
        tv[1]  = mk(1, 1, 1, 15, 12, 0, 1, 1,  1, 12, 1, 1, 1); // contention
        tv[2]  = mk(1, 1, 1, 15, 12, 1, 0, 0,  1, 15, 0, 2, 1);
        tv[3]  = mk(1, 1, 1, 15, 12, 0, 1, 1,  1, 12, 1, 2, 2);
        tv[4]  = mk(1, 1, 1, 15, 12, 1, 0, 0,  1, 15, 0, 3, 2);
        tv[5]  = mk(0, 1, 1, 15, 12, 0, 1, 1,  1, 12, 1, 3, 3);
        tv[6]  = mk(1, 1, 0, 15, 12, 0, 0, 0,  1, 12, 1, 3, 3); // stall
        tv[7]  = mk(1, 1, 0, 15, 12, 0, 0, 0,  1, 12, 1, 3, 3);
        tv[8]  = mk(1, 1, 0, 15, 12, 0, 0, 0,  1, 12, 1, 3, 3);
        tv[9]  = mk(1, 1, 0, 15, 12, 0, 0, 0,  1, 12, 1, 3, 3);
        tv[10] = mk(1, 1, 0, 15, 12, 0, 0, 0,  1, 12, 1, 3, 3);
        tv[11] = mk(1, 1, 1, 15, 12, 1, 0, 0,  1, 15, 0, 4, 3); // A after B
        tv[12] = mk(0, 0, 1, 15, 12, 0, 0, 0,  0, 15, 0, 4, 3); // drain
        tv[13] = mk(0, 0, 0, 15, 12, 0, 0, 0,  0, 15, 0, 4, 3);
        tv[14] = mk(1, 0, 1,  7, 12, 1, 0, 0,  1,  7, 0, 5, 3);
        tv[15] = mk(0, 0, 1,  7, 12, 0, 0, 0,  0,  7, 0, 5, 3);
        tv[16] = mk(0, 1, 0,  7,  9, 0, 1, 1,  1,  9, 1, 5, 4); // EMPTY ignores out_ready
        tv[17] = mk(0, 0, 1,  7,  9, 0, 0, 1,  0,  9, 1, 5, 4); // select held

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_cnt_a", cnt_a, 0);
        check("rst_a_ready_in_reset", a_ready, 0);
        rst_n = 1'b1;
        a_valid = 1'b1; a_data = 64'd5; out_ready = 1'b1;
        @(posedge clk); #1;
        check("pre_cnt_a", cnt_a, 1);
        check("pre_out_data", out_data, 5);
        // Asynchronous reset in the middle of an A transfer
        #2;
        rst_n = 1'b0;
        #1;
        check("async_out_valid", out_valid, 0);
        check("async_out_data", out_data, 0);
        check("async_cnt_a", cnt_a, 0);
        check("async_a_ready", a_ready, 0);
        check("async_select", select, 0);
        @(posedge clk); #1;
        check("hold_rst_out_valid", out_valid, 0);
        check("hold_rst_cnt_a", cnt_a, 0);
        rst_n = 1'b1;
        b_valid = 1'b1; b_data = 64'd12;
        #2;
        check("first_win_a_ready", a_ready, 1);
        check("first_win_b_ready", b_ready, 0);

        for (int i = 0; i < 18; i++) begin
            a_valid = tv[i].av; b_valid = tv[i].bv; out_ready = tv[i].ordy;
            a_data = tv[i].ad; b_data = tv[i].bd;
            #2;
            check($sformatf("v%0d_a_ready", i), a_ready, tv[i].ear);
            check($sformatf("v%0d_b_ready", i), b_ready, tv[i].ebr);
            check($sformatf("v%0d_select", i), select, tv[i].esel);
            @(posedge clk); #1;
            check($sformatf("v%0d_out_valid", i), out_valid, tv[i].eov);
            check($sformatf("v%0d_out_data", i), out_data, tv[i].eod);
            check($sformatf("v%0d_out_src", i), out_src, tv[i].esrc);
            check($sformatf("v%0d_cnt_a", i), cnt_a, tv[i].eca);
            check($sformatf("v%0d_cnt_b", i), cnt_b, tv[i].ecb);
        end

        // Counter wrap on the 4-bit instance
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        a_valid = 1'b1; b_valid = 1'b0; out_ready = 1'b1; a_data = 64'd33;
        repeat (17) @(posedge clk);
        #1;
        a_valid = 1'b0;
        check("wrap_cnt_a4", cnt_a4, 1);
        check("wrap_cnt_b4", cnt_b4, 0);
        check("wrap_cnt_a16", cnt_a, 17);
        check("wrap_out_data4", out_data4, 33);
        check("wrap_out_valid4", out_valid4, 1);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
`default_nettype wire
